// File: rtl/fixed_point_serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// fixed_point_serial_subtractor_if
//   Groups the operand and result valid/ready channels of the serial
//   subtractor.
//   Ports (signals):
//     in_valid, a, b, bin       operand channel, driven by the producer
//     in_ready                  operand channel back-pressure, driven by block
//     out_valid, result, cout,  result channel, driven by the block
//     overflow_flag, negative
//     out_ready                 result channel back-pressure, driven by consumer
//   Modports: master = producer/consumer side, slave = subtractor side.
// ---------------------------------------------------------------------------
interface fixed_point_serial_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow_flag;
   logic             negative;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, result, cout, overflow_flag, negative
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, result, cout, overflow_flag, negative
   );
endinterface

// File: rtl/fixed_point_serial_subtractor.sv
// ---------------------------------------------------------------------------
// fixed_point_serial_subtractor
//   Multi-cycle two's-complement subtractor: result = a - b - bin, computed
//   SLICE bits per cycle (LSB slice first) through a single carry-lookahead
//   slice. Subtraction is done as a + ~b + ~bin, so the carry out of the top
//   slice is the inverted borrow.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   slave side of fixed_point_serial_subtractor_if:
//           in_valid/in_ready + a, b, bin        operand handshake
//           out_valid/out_ready + result, cout,  result handshake; outputs
//           overflow_flag, negative              hold while out_valid=1
//   Latency from accept to out_valid is WIDTH/SLICE cycles.
// ---------------------------------------------------------------------------
module fixed_point_serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   fixed_point_serial_subtractor_if.slave   bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int MSB    = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              in_ready_c;
   logic              out_valid_c;

   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  nb_reg;      // inverted subtrahend
   logic              carry;       // carry into the current slice
   logic [CW-1:0]     cnt;         // index of the slice being computed
   logic              last_slice;

   logic [WIDTH-1:0]  result_reg;
   logic              cout_reg;
   logic              ovf_reg;
   logic              neg_reg;

   logic [SLICE-1:0]  a_s;
   logic [SLICE-1:0]  b_s;
   logic [SLICE-1:0]  gen;
   logic [SLICE-1:0]  prop;
   logic [SLICE:0]    c;
   logic [SLICE-1:0]  sum;

   assign last_slice = (cnt == CW'(NSLICE - 1));

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // ------------------------------------------------------------------------
   // FSM next state and handshake outputs
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_next  = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_next = CALC;
         end
         CALC: begin
            if (last_slice) state_next = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // One carry-lookahead slice. Each carry is built directly from generate /
   // propagate terms of the lower bits and the slice carry-in, not rippled.
   // ------------------------------------------------------------------------
   always_comb begin
      a_s  = a_reg[int'(cnt)*SLICE +: SLICE];
      b_s  = nb_reg[int'(cnt)*SLICE +: SLICE];
      gen  = a_s & b_s;
      prop = a_s ^ b_s;
      c    = '0;
      c[0] = carry;
      for (int i = 0; i < SLICE; i++) begin
         logic term;
         logic prod;
         term = gen[i];
         prod = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            term = term | (prod & gen[j]);
            prod = prod & prop[j];
         end
         c[i+1] = term | (prod & carry);
      end
      sum = prop ^ c[SLICE-1:0];
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   // NOTE: only the externally visible result/flag registers and the control
   // counters are reset; the operand registers are always loaded on accept
   // before they are read, so they carry no reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry      <= 1'b0;
         cnt        <= '0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         neg_reg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  carry <= ~bus.bin;
                  cnt   <= '0;
               end
            end
            CALC: begin
               result_reg[int'(cnt)*SLICE +: SLICE] <= sum;
               carry <= c[SLICE];
               cnt   <= cnt + CW'(1);
               if (last_slice) begin
                  cout_reg <= ~c[SLICE];
                  neg_reg  <= sum[SLICE-1];
                  // Operands differ in sign (a[MSB] == ~b[MSB]) and the
                  // result sign differs from the minuend.
                  ovf_reg  <= (a_reg[MSB] == nb_reg[MSB]) &
                              (sum[SLICE-1] != a_reg[MSB]);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && bus.in_valid) begin
         a_reg  <= bus.a;
         nb_reg <= ~bus.b;
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_valid_c;
   assign bus.result        = result_reg;
   assign bus.cout          = cout_reg;
   assign bus.overflow_flag = ovf_reg;
   assign bus.negative      = neg_reg;

endmodule

// File: tb/tb_fixed_point_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_serial_subtractor
//   Self-checking bench for fixed_point_serial_subtractor. Expected values
//   come from directed constants and an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fixed_point_serial_subtractor;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int LAT   = WIDTH / SLICE;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fixed_point_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   fixed_point_serial_subtractor #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {result, cout, overflow, negative} from plain arithmetic.
   function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic bin);
      int          sd;
      int unsigned ua;
      int unsigned ub;
      logic [WIDTH-1:0] r;
      logic        brw;
      logic        ovf;
      sd  = int'($signed(a)) - int'($signed(b)) - int'(bin);
      ua  = int'(a);
      ub  = int'(b);
      r   = sd[WIDTH-1:0];
      brw = (ua < ub + int'(bin));
      ovf = (sd > 32767) || (sd < -32768);
      return {r, brw, ovf, r[WIDTH-1]};
   endfunction

   function automatic logic [WIDTH+2:0] observed();
      return {bus.result, bus.cout, bus.overflow_flag, bus.negative};
   endfunction

   // One full transaction starting from IDLE, 1 time unit after a rising edge.
   // Operand inputs are scrambled after accept to show they are not resampled.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, output logic [WIDTH+2:0] obs,
                         output int lat);
      bus.a        = a;
      bus.b        = b;
      bus.bin      = bin;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.bin      = 1'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      obs = observed();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bin       = 1'b0;
      rst           = 1'b1;
      #2;
      total++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL reset_handshake: got in_ready/out_valid=%b expected 10",
                  {bus.in_ready, bus.out_valid});
      end
      total++;
      if (observed() !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h expected 0", observed());
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL post_reset_idle: got in_ready/out_valid=%b expected 10",
                  {bus.in_ready, bus.out_valid});
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             bin;
      logic [WIDTH+2:0] exp;
   } vec_t;

   task automatic test_directed;
      vec_t v[5];
      logic [WIDTH+2:0] obs;
      int lat;
      v[0] = '{16'h0005, 16'h0003, 1'b0, {16'h0002, 3'b000}};
      v[1] = '{16'h0003, 16'h0005, 1'b0, {16'hFFFE, 3'b101}};
      v[2] = '{16'h8000, 16'h0001, 1'b0, {16'h7FFF, 3'b010}};
      v[3] = '{16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 3'b111}};
      v[4] = '{16'h0010, 16'h000F, 1'b1, {16'h0000, 3'b000}};
      foreach (v[i]) begin
         run_op(v[i].a, v[i].b, v[i].bin, obs, lat);
         total++;
         if (lat !== LAT) begin
            bad++;
            $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
         end
         total++;
         if (obs !== v[i].exp) begin
            bad++;
            $display("FAIL directed[%0d]: got res/c/v/n=%h expected %h", i, obs, v[i].exp);
         end
      end
   endtask

   task automatic test_random;
      logic [WIDTH+2:0] obs;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic bin;
      int lat;
      for (int i = 0; i < 40; i++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         bin = 1'($urandom);
         if (i % 8 == 0) a = 16'h8000;
         if (i % 8 == 1) b = 16'hFFFF;
         if (i % 8 == 2) a = 16'h0000;
         run_op(a, b, bin, obs, lat);
         total++;
         if (obs !== model(a, b, bin) || lat !== LAT) begin
            bad++;
            $display("FAIL random[%0d] a=%h b=%h bin=%b: got %h lat=%0d expected %h lat=%0d",
                     i, a, b, bin, obs, lat, model(a, b, bin), LAT);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [WIDTH+2:0] obs;
      logic [WIDTH+2:0] exp1;
      int lat;
      exp1 = model(16'h1234, 16'h0234, 1'b0);
      bus.a = 16'h1234; bus.b = 16'h0234; bus.bin = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.a = 16'h0100; bus.b = 16'h0001; bus.bin = 1'b1;   // held valid, must wait
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (observed() !== exp1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got %h rdy=%b vld=%b expected %h rdy=0 vld=1",
                     i, observed(), bus.in_ready, bus.out_valid, exp1);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      total++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL after_handshake: got in_ready/out_valid=%b expected 10",
                  {bus.in_ready, bus.out_valid});
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL second_accept: got in_ready=%b expected 0", bus.in_ready);
      end
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      obs = observed();
      total++;
      if (obs !== model(16'h0100, 16'h0001, 1'b1) || lat !== LAT) begin
         bad++;
         $display("FAIL stalled_next_op: got %h lat=%0d expected %h lat=%0d",
                  obs, lat, model(16'h0100, 16'h0001, 1'b1), LAT);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_calc;
      int seen;
      bus.a = 16'h4321; bus.b = 16'h1111; bus.bin = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10 || observed() !== '0) begin
         bad++;
         $display("FAIL reset_mid_calc: got rdy/vld=%b outs=%h expected 10 and 0",
                  {bus.in_ready, bus.out_valid}, observed());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL stale_after_reset: got %0d bad cycles expected 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int               acc_cyc[$];
      logic [WIDTH+2:0] res[$];
      logic [WIDTH+2:0] exp_a;
      logic [WIDTH+2:0] exp_b;
      logic             acc;
      exp_a = model(16'hA5A5, 16'h5A5A, 1'b1);
      exp_b = model(16'h0001, 16'h8000, 1'b0);
      bus.a = 16'hA5A5; bus.b = 16'h5A5A; bus.bin = 1'b1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 40 && res.size() < 2; c++) begin
         acc = bus.in_ready && bus.in_valid;
         if (bus.out_valid) res.push_back(observed());
         @(posedge clk); #1;
         if (acc) begin
            acc_cyc.push_back(c);
            if (acc_cyc.size() == 1) begin
               bus.a = 16'h0001; bus.b = 16'h8000; bus.bin = 1'b0;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      total++;
      if (acc_cyc.size() != 2 || res.size() != 2) begin
         bad++;
         $display("FAIL b2b_count: got accepts=%0d results=%0d expected 2 and 2",
                  acc_cyc.size(), res.size());
      end else begin
         total++;
         if (acc_cyc[1] - acc_cyc[0] !== LAT + 2) begin
            bad++;
            $display("FAIL b2b_interval: got %0d expected %0d",
                     acc_cyc[1] - acc_cyc[0], LAT + 2);
         end
         total++;
         if (res[0] !== exp_a || res[1] !== exp_b) begin
            bad++;
            $display("FAIL b2b_results: got %h,%h expected %h,%h",
                     res[0], res[1], exp_a, exp_b);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset;
      test_directed;
      test_random;
      test_backpressure;
      test_reset_mid_calc;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule
